mole_round_ctrl: RTL
====================

// Module: mole_round_ctrl
// PURPOSE
//  Round sequencer for whack-a-mole: picks a mole, lights it, runs a per-round
//  seconds countdown, judges button hits, keeps score/round count, ends game
//  after NUM_ROUNDS. Sits between debounced button inputs and LED/7-seg drivers.
// PARAMETERS
//  NUM_MOLES      8            moles/buttons; power of two, 2..16
//  ROUND_SECS     5            countdown load per round, 1..15
//  NUM_ROUNDS     10           rounds per game, 1..255
//  FEEDBACK_SECS  1            hit/miss display time, 1..15
//  TICK_DIV       100_000_000  clk cycles per second tick, >=2
// PORTS
//  clk        in   1          system clock
//  reset      in   1          asynchronous, active-low reset
//  start      in   1          1-cycle pulse: begin game (IDLE/GAMEOVER only)
//  btn_hit    in   NUM_MOLES  debounced 1-cycle press pulses, one bit per mole
//  mole_led   out  NUM_MOLES  one-hot active mole; 0 outside ACTIVE
//  countdown  out  4          seconds left in current round
//  score      out  8          hits this game, saturating at 255
//  round_num  out  8          current round, 1..NUM_ROUNDS; 0 in IDLE
//  hit_flash  out  1          high throughout HIT state
//  miss_flash out  1          high throughout MISS state
//  game_over  out  1          high throughout GAMEOVER state
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE; all outputs 0; prescaler 0; LFSR=16'hACE1.
//  Tick: prescaler counts 0..TICK_DIV-1, tick=1 for the cycle count==TICK_DIV-1.
//   Prescaler cleared on every entry to ARM, HIT, MISS -> full first second.
//  LFSR: 16-bit Galois, taps 16'hB400, advances every clk in all states.
//  States / transitions (registered, one per cycle):
//   IDLE   : start -> ARM; round_num<=1, score<=0.
//   ARM    : 1 cycle. idx=lfsr[log2(NUM_MOLES)-1:0]; if idx==prev idx use
//            idx+1 mod NUM_MOLES; latch mole; countdown<=ROUND_SECS -> ACTIVE.
//   ACTIVE : mole_led=onehot(mole). Per cycle, priority order:
//            1) btn_hit==onehot(mole) exactly -> HIT, score+=1 (sat 255)
//            2) btn_hit!=0 otherwise (wrong or multiple) -> MISS
//            3) tick && countdown==1 -> countdown<=0, MISS (timeout)
//            4) tick -> countdown-=1
//            Press and final tick in same cycle: press wins.
//   HIT/MISS: countdown frozen; stay FEEDBACK_SECS ticks; then
//            round_num==NUM_ROUNDS -> GAMEOVER, else round_num+=1 -> ARM.
//   GAMEOVER: outputs held; start -> ARM with score<=0, round_num<=1.
//  start ignored in ARM/ACTIVE/HIT/MISS; btn_hit ignored outside ACTIVE.
//  Latency: start -> mole_led valid = 2 cycles (ARM then ACTIVE).
//  Button -> hit_flash/miss_flash = 1 cycle.
//  countdown never wraps below 0; score never wraps past 255.
//  Reset mid-round: immediate return to IDLE, no score retained.
// STRUCTURE
//  Shared package game_pkg: state encoding (IDLE=0,ARM=1,ACTIVE=2,HIT=3,MISS=4,
//   GAMEOVER=5, 3-bit), LFSR seed 16'hACE1 and taps 16'hB400 constants.
//  Sub-module sec_tick_gen (TICK_DIV; clk, reset, clr -> tick): prescaler only.
//  FSM, LFSR, mole select, countdown, score/round counters in this module.
// TESTING (TICK_DIV=4, ROUND_SECS=5, NUM_ROUNDS=3, FEEDBACK_SECS=1, NUM_MOLES=8)
//  1 reset low mid-ACTIVE -> same cycle all outputs 0, state IDLE; start after
//    release -> mole_led one-hot 2 cycles later, countdown=5, round_num=1.
//  2 no press -> countdown 5,4,3,2,1 at 4-cycle steps, 0 after 20 cycles in
//    ACTIVE; miss_flash high 4 cycles; score stays 0; round_num -> 2.
//  3 press matching bit during ACTIVE -> next cycle hit_flash=1, score=1,
//    countdown frozen; after 4 cycles new ARM, new mole differs from previous.
//  4 press two bits incl. correct one -> miss_flash, score unchanged.
//  5 correct press on same cycle as final tick (countdown==1) -> HIT, score+1.
//  6 3 rounds played -> game_over=1, outputs hold; start ignored mid-round;
//    start in GAMEOVER -> score=0, round_num=1, new ACTIVE round.

Source files
------------

// File: rtl/game_pkg.sv
// Shared whack-a-mole definitions: FSM state encoding and the mole-picking LFSR.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ARM      = 3'd1,
        ACTIVE   = 3'd2,
        HIT      = 3'd3,
        MISS     = 3'd4,
        GAMEOVER = 3'd5
    } game_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsr_step(input logic [15:0] value);
        return {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Seconds prescaler: one-cycle tick every TICK_DIV clocks, restartable with clr.
module sec_tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: mole selection, round countdown, hit judging,
// score and round bookkeeping.
module mole_round_ctrl
    import game_pkg::*;
#(
    parameter int NUM_MOLES     = 8,
    parameter int ROUND_SECS    = 5,
    parameter int NUM_ROUNDS    = 10,
    parameter int FEEDBACK_SECS = 1,
    parameter int TICK_DIV      = 100_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] btn_hit,
    output logic [NUM_MOLES-1:0] mole_led,
    output logic [3:0]           countdown,
    output logic [7:0]           score,
    output logic [7:0]           round_num,
    output logic                 hit_flash,
    output logic                 miss_flash,
    output logic                 game_over
);

    localparam int IW = $clog2(NUM_MOLES);
    localparam logic [3:0] CD_LOAD    = 4'(ROUND_SECS);
    localparam logic [3:0] FB_LAST    = 4'(FEEDBACK_SECS - 1);
    localparam logic [7:0] ROUND_LAST = 8'(NUM_ROUNDS);

    game_state_t state, state_next;

    logic [15:0]          lfsr;
    logic [IW-1:0]        mole;
    logic [IW-1:0]        raw_idx;
    logic [IW-1:0]        pick;
    logic [NUM_MOLES-1:0] mole_onehot;
    logic [3:0]           fb_cnt;
    logic                 fb_last;
    logic                 tick;
    logic                 clr;

    sec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .tick  (tick)
    );

    // Never light the same mole twice in a row; power-of-two count makes +1 wrap.
    assign raw_idx     = lfsr[IW-1:0];
    assign pick        = (raw_idx == mole) ? raw_idx + 1'b1 : raw_idx;
    assign mole_onehot = {{(NUM_MOLES-1){1'b0}}, 1'b1} << mole;
    assign fb_last     = (fb_cnt == FB_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = ARM;
            ARM:      state_next = ACTIVE;
            ACTIVE: begin
                if (btn_hit == mole_onehot) begin
                    state_next = HIT;
                end else if (btn_hit != '0) begin
                    state_next = MISS;
                end else if (tick && countdown == 4'd1) begin
                    state_next = MISS;
                end
            end
            HIT, MISS: begin
                if (tick && fb_last) begin
                    state_next = (round_num == ROUND_LAST) ? GAMEOVER : ARM;
                end
            end
            GAMEOVER: if (start) state_next = ARM;
            default:  state_next = IDLE;
        endcase
    end

    // Holding the prescaler clear through ARM gives ACTIVE a full first second.
    always_comb begin
        clr = (state == ARM);
        if (state_next != state &&
            (state_next == ARM || state_next == HIT || state_next == MISS)) begin
            clr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr      <= LFSR_SEED;
            mole      <= '0;
            countdown <= '0;
            score     <= '0;
            round_num <= '0;
            fb_cnt    <= '0;
        end else begin
            lfsr <= lfsr_step(lfsr);
            case (state)
                IDLE, GAMEOVER: begin
                    if (start) begin
                        score     <= '0;
                        round_num <= 8'd1;
                    end
                end
                ARM: begin
                    mole      <= pick;
                    countdown <= CD_LOAD;
                end
                ACTIVE: begin
                    fb_cnt <= '0;
                    if (state_next == HIT) begin
                        score <= (score == 8'hFF) ? score : score + 8'd1;
                    end else if (btn_hit == '0 && tick && countdown != 4'd0) begin
                        countdown <= countdown - 4'd1;
                    end
                end
                HIT, MISS: begin
                    if (tick) begin
                        if (!fb_last) begin
                            fb_cnt <= fb_cnt + 4'd1;
                        end else if (state_next == ARM) begin
                            round_num <= round_num + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mole_led   = (state == ACTIVE) ? mole_onehot : '0;
    assign hit_flash  = (state == HIT);
    assign miss_flash = (state == MISS);
    assign game_over  = (state == GAMEOVER);

endmodule
